// File: rtl/mem_cache_pkg.sv
// Shared types and default geometry for the MEM-stage word cache.
// Imported by the cache top and its storage array.
package mem_cache_pkg;

    localparam int INDEX_W_DEF = 6;
    localparam int ADDR_W_DEF  = 18;
    localparam int TAG_W       = ADDR_W_DEF - INDEX_W_DEF - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_e;

    function automatic int tag_width(input int addr_w, input int index_w);
        return addr_w - index_w - 1;
    endfunction

endpackage

// File: rtl/mem_cache_store.sv
// Direct-mapped line storage: valid/tag/data arrays with a combinational
// lookup port and one write port used for both fills and write-hit updates.
module cache_store
    import mem_cache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int TAG_W   = tag_width(ADDR_W_DEF, INDEX_W_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [INDEX_W-1:0] lk_index,
    input  logic [TAG_W-1:0]   lk_tag,
    output logic               hit,
    output logic [31:0]        lk_data,
    input  logic               we,
    input  logic               fill,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_data
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    assign hit     = valid_q[lk_index] && (tag_mem[lk_index] == lk_tag);
    assign lk_data = data_mem[lk_index];

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end
        if (we && fill) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data need no reset: a line is only ever read through its valid bit.
    always_ff @(posedge clk) begin
        if (we) begin
            data_mem[wr_index] <= wr_data;
            if (fill) begin
                tag_mem[wr_index] <= wr_tag;
            end
        end
    end

endmodule

// File: rtl/mem_cache.sv
// Write-through, no-write-allocate word cache in front of the SRAM controller.
// Read hits finish in the request cycle; misses and writes freeze via ready.
module mem_cache
    import mem_cache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    input  logic              flush,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic              sram_rd_en,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_write_data,
    input  logic [31:0]       sram_read_data,
    input  logic              sram_ready
);

    localparam int TW = tag_width(ADDR_W, INDEX_W);

    state_e state_q;
    state_e state_d;

    logic [INDEX_W-1:0] index;
    logic [TW-1:0]      tag;
    logic               unused_addr_lsb;

    logic        hit;
    logic [31:0] hit_data;
    logic        st_we;
    logic        st_fill;
    logic        st_flush;
    logic [31:0] st_wdata;

    assign index           = addr[INDEX_W:1];
    assign tag             = addr[ADDR_W-1:INDEX_W+1];
    assign unused_addr_lsb = addr[0];

    assign sram_addr       = addr;
    assign sram_write_data = write_data;

    cache_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TW)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .flush    (st_flush),
        .lk_index (index),
        .lk_tag   (tag),
        .hit      (hit),
        .lk_data  (hit_data),
        .we       (st_we),
        .fill     (st_fill),
        .wr_index (index),
        .wr_tag   (tag),
        .wr_data  (st_wdata)
    );

    always_comb begin
        state_d    = state_q;
        ready      = 1'b1;
        read_data  = '0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        st_we      = 1'b0;
        st_fill    = 1'b0;
        st_flush   = 1'b0;
        st_wdata   = write_data;

        unique case (state_q)
            IDLE: begin
                st_flush = flush;
                if (wr_en) begin
                    ready      = 1'b0;
                    sram_wr_en = 1'b1;
                    state_d    = WR_THRU;
                end else if (rd_en) begin
                    if (hit) begin
                        read_data = hit_data;
                    end else begin
                        ready      = 1'b0;
                        sram_rd_en = 1'b1;
                        state_d    = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                sram_rd_en = 1'b1;
                st_wdata   = sram_read_data;
                if (sram_ready) begin
                    read_data = sram_read_data;
                    st_we     = 1'b1;
                    st_fill   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    ready = 1'b0;
                end
            end
            WR_THRU: begin
                sram_wr_en = 1'b1;
                if (sram_ready) begin
                    st_we   = hit;
                    state_d = IDLE;
                end else begin
                    ready = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset must drop the SRAM request at once, even with rd_en held.
        if (!rst) begin
            ready      = 1'b1;
            read_data  = '0;
            sram_rd_en = 1'b0;
            sram_wr_en = 1'b0;
            st_we      = 1'b0;
            st_fill    = 1'b0;
            st_flush   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_mem_cache.sv
// Randomized bench for mem_cache: transaction-level cache model plus an
// SRAM controller model with programmable latency.
module tb_mem_cache;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [17:0] addr;
    logic [31:0] write_data;
    logic        flush;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [17:0] sram_addr;
    logic [31:0] sram_write_data;
    logic [31:0] sram_read_data;
    logic        sram_ready;

    int n_checks = 0;
    int n_errors = 0;

    bit          mvalid [64];
    int          mtag   [64];
    logic [31:0] mdata  [64];
    logic [31:0] smem   [int];

    mem_cache dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .wr_en           (wr_en),
        .addr            (addr),
        .write_data      (write_data),
        .flush           (flush),
        .read_data       (read_data),
        .ready           (ready),
        .sram_rd_en      (sram_rd_en),
        .sram_wr_en      (sram_wr_en),
        .sram_addr       (sram_addr),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data),
        .sram_ready      (sram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sram_get(input int a);
        if (!smem.exists(a)) smem[a] = $urandom;
        return smem[a];
    endfunction

    function automatic bit model_hit(input int a);
        int idx = (a >> 1) & 63;
        int tg  = a >> 7;
        return mvalid[idx] && (mtag[idx] == tg);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check({tag, "_rdata"}, read_data, 32'd0);
        check({tag, "_sram"}, {30'd0, sram_rd_en, sram_wr_en}, 32'd0);
    endtask

    task automatic access(input bit is_wr, input int a, input logic [31:0] wd,
                          input int lat, input bit mid_flush);
        int          idx = (a >> 1) & 63;
        int          tg  = a >> 7;
        bit          h   = model_hit(a);
        logic [31:0] rv  = '0;
        @(posedge clk); #1;
        addr       = a[17:0];
        write_data = wd;
        wr_en      = is_wr;
        rd_en      = !is_wr;
        sram_ready = 1'b0;
        flush      = 1'b0;
        @(negedge clk);
        check("sram_addr", {14'd0, sram_addr}, a);
        check("sram_wdata", sram_write_data, wd);
        if (!is_wr && h) begin
            check("hit_ready", {31'd0, ready}, 32'd1);
            check("hit_data", read_data, mdata[idx]);
            check("hit_sram", {30'd0, sram_rd_en, sram_wr_en}, 32'd0);
        end else begin
            check("req_ready", {31'd0, ready}, 32'd0);
            check("req_en", {30'd0, sram_rd_en, sram_wr_en},
                  is_wr ? 32'd1 : 32'd2);
            if (!is_wr) rv = sram_get(a);
            for (int c = 1; c <= lat; c++) begin
                @(posedge clk); #1;
                sram_ready     = (c == lat);
                sram_read_data = (c == lat && !is_wr) ? rv : $urandom;
                flush          = mid_flush && (c == 1);
                @(negedge clk);
                check("busy_ready", {31'd0, ready}, (c == lat) ? 32'd1 : 32'd0);
                check("busy_en", {30'd0, sram_rd_en, sram_wr_en},
                      is_wr ? 32'd1 : 32'd2);
                if (c == lat && !is_wr) check("miss_data", read_data, rv);
            end
        end
        @(posedge clk);
        if (is_wr) begin
            smem[a] = wd;
            if (h) mdata[idx] = wd;
        end else if (!h) begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
            mdata[idx]  = rv;
        end
        #1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        flush      = 1'b0;
        sram_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_idle("after");
    endtask

    task automatic do_flush(input bit with_rd, input int a);
        int idx = (a >> 1) & 63;
        bit h   = model_hit(a);
        @(posedge clk); #1;
        addr       = a[17:0];
        flush      = 1'b1;
        rd_en      = with_rd && h;
        sram_ready = 1'b0;
        @(negedge clk);
        if (with_rd && h) begin
            check("flush_hit_ready", {31'd0, ready}, 32'd1);
            check("flush_hit_data", read_data, mdata[idx]);
        end else begin
            check_idle("flush");
        end
        @(posedge clk);
        clear_model();
        #1;
        flush = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic reset_mid(input int a);
        do_flush(1'b0, 0);
        @(posedge clk); #1;
        addr  = a[17:0];
        rd_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sram_read_data = $urandom;
        rst = 1'b0;
        #1;
        check("rst_mid_rd_en", {31'd0, sram_rd_en}, 32'd0);
        check("rst_mid_ready", {31'd0, ready}, 32'd1);
        check("rst_mid_rdata", read_data, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        rd_en = 1'b0;
        clear_model();
        access(1'b0, a, 32'd0, 2, 1'b0);
    endtask

    function automatic int rand_addr();
        return (int'($urandom_range(0, 3)) << 7) | (int'($urandom_range(0, 7)) << 1);
    endfunction

    initial begin
        rst            = 1'b0;
        rd_en          = 1'b0;
        wr_en          = 1'b0;
        addr           = '0;
        write_data     = '0;
        flush          = 1'b0;
        sram_read_data = '0;
        sram_ready     = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;

        smem[0] = 32'hDEADBEEF;
        access(1'b0, 'h000, 32'd0, 4, 1'b0);
        access(1'b0, 'h000, 32'd0, 1, 1'b0);
        access(1'b1, 'h000, 32'h12345678, 3, 1'b0);
        access(1'b0, 'h000, 32'd0, 1, 1'b0);
        access(1'b1, 'h004, 32'hCAFEF00D, 2, 1'b0);
        access(1'b0, 'h004, 32'd0, 2, 1'b0);
        access(1'b0, 'h080, 32'd0, 3, 1'b0);
        access(1'b0, 'h000, 32'd0, 1, 1'b0);
        do_flush(1'b1, 'h000);
        access(1'b0, 'h000, 32'd0, 2, 1'b0);
        access(1'b0, 'h080, 32'd0, 2, 1'b0);
        access(1'b0, 'h100, 32'd0, 3, 1'b1);
        access(1'b0, 'h100, 32'd0, 1, 1'b0);
        access(1'b1, 'h102, 32'h0BADCAFE, 2, 1'b1);
        reset_mid('h000);

        for (int n = 0; n < 400; n++) begin
            int k = $urandom_range(0, 19);
            if (k == 0) begin
                do_flush(1'($urandom_range(0, 1)), rand_addr());
            end else begin
                access(k < 6, rand_addr(), $urandom,
                       $urandom_range(1, 4), (k % 7) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
